// File: rtl/pads_pkg.sv
// Shared definitions for the pad-side GPIO blocks: register word addresses
// and the register interface address width.
package pads_pkg;

    localparam int REG_ADDR_W = 4;

    localparam logic [REG_ADDR_W-1:0] ADDR_OUT     = 4'h0;
    localparam logic [REG_ADDR_W-1:0] ADDR_OE      = 4'h1;
    localparam logic [REG_ADDR_W-1:0] ADDR_IE      = 4'h2;
    localparam logic [REG_ADDR_W-1:0] ADDR_IN      = 4'h3;
    localparam logic [REG_ADDR_W-1:0] ADDR_RISE_EN = 4'h4;
    localparam logic [REG_ADDR_W-1:0] ADDR_FALL_EN = 4'h5;
    localparam logic [REG_ADDR_W-1:0] ADDR_STATUS  = 4'h6;
    localparam logic [REG_ADDR_W-1:0] ADDR_OUT_SET = 4'h7;
    localparam logic [REG_ADDR_W-1:0] ADDR_OUT_CLR = 4'h8;

endpackage

// File: rtl/pads_gpio_ctrl_if.sv
// Single-cycle register bus between the SoC and the GPIO controller.
// Handshake: reg_req is a one-cycle strobe sampled on a rising clk edge;
// reg_ack is high for exactly the following cycle, with reg_rdata valid
// (and zero otherwise). There is no stall: a new request may be issued
// every cycle and each one gets its own ack.
interface pads_gpio_ctrl_if
    import pads_pkg::*;
#(
    parameter int N = 8
);
    logic                  reg_req;
    logic                  reg_we;
    logic [REG_ADDR_W-1:0] reg_addr;
    logic [N-1:0]          reg_wdata;
    logic [N-1:0]          reg_rdata;
    logic                  reg_ack;

    modport master (
        output reg_req, reg_we, reg_addr, reg_wdata,
        input  reg_rdata, reg_ack
    );

    modport slave (
        input  reg_req, reg_we, reg_addr, reg_wdata,
        output reg_rdata, reg_ack
    );
endinterface

// File: rtl/pads_sync.sv
// N-wide, STAGES-deep flop synchronizer for asynchronous pad inputs.
// Shared by the pad-side blocks; all stages clear on reset.
module pads_sync #(
    parameter int N      = 8,
    parameter int STAGES = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] d_i,
    output logic [N-1:0] q_o
);

    logic [N-1:0] stage_q [STAGES];

    // Shift the raw input through the synchronizer chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/pads_gpio_ctrl.sv
// GPIO controller for one pad side: register file driving pad_out/oe/ie,
// synchronized pad inputs, edge detection into a sticky STATUS and a
// registered level interrupt.
module pads_gpio_ctrl
    import pads_pkg::*;
#(
    parameter int N           = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    pads_gpio_ctrl_if.slave        bus,
    input  logic [N-1:0]           pad_in,
    output logic [N-1:0]           pad_out,
    output logic [N-1:0]           pad_oe,
    output logic [N-1:0]           pad_ie,
    output logic                   irq
);

    // Blanking covers the synchronizer fill plus the prev stage, so a pin
    // that is already high when reset releases never looks like an edge.
    localparam int                 BLANK_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [BLANK_W-1:0] BLANK_INIT = BLANK_W'(SYNC_STAGES + 1);

    logic [N-1:0]       sync;
    logic [N-1:0]       prev_q;
    logic [N-1:0]       out_q, out_d;
    logic [N-1:0]       oe_q, oe_d;
    logic [N-1:0]       ie_q, ie_d;
    logic [N-1:0]       rise_en_q, rise_en_d;
    logic [N-1:0]       fall_en_q, fall_en_d;
    logic [N-1:0]       status_q, status_d;
    logic [N-1:0]       rdata_q, rdata_d;
    logic               ack_q;
    logic               irq_q;
    logic [BLANK_W-1:0] blank_q, blank_d;
    logic [N-1:0]       clr;
    logic [N-1:0]       rise;
    logic [N-1:0]       fall;
    logic               edge_ok;
    logic               wr;
    logic               rd;

    pads_sync #(
        .N      (N),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d_i (pad_in),
        .q_o (sync)
    );

    assign wr = bus.reg_req & bus.reg_we;
    assign rd = bus.reg_req & ~bus.reg_we;

    // Register file writes, W1C clear mask and read mux.
    always_comb begin
        out_d     = out_q;
        oe_d      = oe_q;
        ie_d      = ie_q;
        rise_en_d = rise_en_q;
        fall_en_d = fall_en_q;
        clr       = '0;
        rdata_d   = '0;
        if (wr) begin
            case (bus.reg_addr)
                ADDR_OUT:     out_d     = bus.reg_wdata;
                ADDR_OE:      oe_d      = bus.reg_wdata;
                ADDR_IE:      ie_d      = bus.reg_wdata;
                ADDR_RISE_EN: rise_en_d = bus.reg_wdata;
                ADDR_FALL_EN: fall_en_d = bus.reg_wdata;
                ADDR_STATUS:  clr       = bus.reg_wdata;
                ADDR_OUT_SET: out_d     = out_q | bus.reg_wdata;
                ADDR_OUT_CLR: out_d     = out_q & ~bus.reg_wdata;
                default:      ;
            endcase
        end
        if (rd) begin
            case (bus.reg_addr)
                ADDR_OUT:     rdata_d = out_q;
                ADDR_OE:      rdata_d = oe_q;
                ADDR_IE:      rdata_d = ie_q;
                ADDR_IN:      rdata_d = sync;
                ADDR_RISE_EN: rdata_d = rise_en_q;
                ADDR_FALL_EN: rdata_d = fall_en_q;
                ADDR_STATUS:  rdata_d = status_q;
                default:      rdata_d = '0;
            endcase
        end
    end

    // Edge detection gated by blanking; a new edge beats a same-cycle clear.
    always_comb begin
        edge_ok  = (blank_q == '0);
        rise     = sync & ~prev_q & rise_en_q & {N{edge_ok}};
        fall     = ~sync & prev_q & fall_en_q & {N{edge_ok}};
        status_d = (status_q & ~clr) | rise | fall;
        blank_d  = edge_ok ? blank_q : blank_q - BLANK_W'(1);
    end

    // Control and status state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_q     <= '0;
            oe_q      <= '0;
            ie_q      <= '1;
            rise_en_q <= '0;
            fall_en_q <= '0;
            status_q  <= '0;
            prev_q    <= '0;
            blank_q   <= BLANK_INIT;
            irq_q     <= 1'b0;
        end else begin
            out_q     <= out_d;
            oe_q      <= oe_d;
            ie_q      <= ie_d;
            rise_en_q <= rise_en_d;
            fall_en_q <= fall_en_d;
            status_q  <= status_d;
            prev_q    <= sync;
            blank_q   <= blank_d;
            irq_q     <= |status_q;
        end
    end

    // Bus response: ack and read data for the cycle after the request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q   <= bus.reg_req;
            rdata_q <= rdata_d;
        end
    end

    assign bus.reg_ack   = ack_q;
    assign bus.reg_rdata = rdata_q;
    assign pad_out       = out_q;
    assign pad_oe        = oe_q;
    assign pad_ie        = ie_q;
    assign irq           = irq_q;

endmodule

// File: tb/tb_pads_gpio_ctrl.sv
// Directed bench for pads_gpio_ctrl (N=8, SYNC_STAGES=2).
module tb_pads_gpio_ctrl;

  logic       clk;
  logic       rst;
  logic [7:0] pad_in;
  logic [7:0] pad_out;
  logic [7:0] pad_oe;
  logic [7:0] pad_ie;
  logic       irq;

  int checks = 0;
  int errors = 0;

  pads_gpio_ctrl_if #(.N(8)) bus ();

  pads_gpio_ctrl #(
    .N           (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .pad_in  (pad_in),
    .pad_out (pad_out),
    .pad_oe  (pad_oe),
    .pad_ie  (pad_ie),
    .irq     (irq)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance n cycles, landing 1ns after a rising edge
  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // one register access; request sampled at the next edge, ack checked after it
  task automatic acc(input logic we, input logic [3:0] addr, input logic [7:0] wd,
                     output logic [7:0] rd);
    bus.reg_req   = 1'b1;
    bus.reg_we    = we;
    bus.reg_addr  = addr;
    bus.reg_wdata = wd;
    @(posedge clk);
    #1;
    chk($sformatf("ack_%0h", addr), 32'(bus.reg_ack), 32'd1);
    rd = bus.reg_rdata;
    bus.reg_req   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_wdata = 8'h00;
  endtask

  logic [7:0] rd;
  logic [7:0] rst_exp [16];
  logic [7:0] map_exp [9];

  initial begin
    rst           = 1'b0;
    pad_in        = 8'h00;
    bus.reg_req   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_addr  = 4'h0;
    bus.reg_wdata = 8'h00;
    #1 rst = 1'b1;
    idle(3);

    // reset state
    chk("rst_pad_out", 32'(pad_out), 32'h00);
    chk("rst_pad_oe", 32'(pad_oe), 32'h00);
    chk("rst_pad_ie", 32'(pad_ie), 32'hFF);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_ack", 32'(bus.reg_ack), 32'd0);
    chk("rst_rdata", 32'(bus.reg_rdata), 32'h00);
    rst = 1'b0;

    // reset readout of all addresses, ack lasts exactly one cycle
    for (int a = 0; a < 16; a++) rst_exp[a] = 8'h00;
    rst_exp[2] = 8'hFF;
    for (int a = 0; a < 16; a++) begin
      acc(1'b0, 4'(a), 8'h00, rd);
      chk($sformatf("rst_rd_%0h", a), 32'(rd), 32'(rst_exp[a]));
      idle(1);
      chk($sformatf("ack_drop_%0h", a), 32'(bus.reg_ack), 32'd0);
      chk($sformatf("rdata_idle_%0h", a), 32'(bus.reg_rdata), 32'h00);
    end
    chk("irq_after_rst", 32'(irq), 32'd0);

    // output path, visible at the ack edge
    acc(1'b1, 4'h0, 8'hA5, rd);
    chk("out_a5", 32'(pad_out), 32'hA5);
    acc(1'b1, 4'h1, 8'h0F, rd);
    chk("oe_0f", 32'(pad_oe), 32'h0F);
    acc(1'b1, 4'h7, 8'h02, rd);
    chk("out_set", 32'(pad_out), 32'hA7);
    acc(1'b1, 4'h8, 8'h81, rd);
    chk("out_clr", 32'(pad_out), 32'h26);
    acc(1'b1, 4'h2, 8'hF0, rd);
    chk("ie_f0", 32'(pad_ie), 32'hF0);
    acc(1'b1, 4'h3, 8'hAA, rd);
    acc(1'b0, 4'h3, 8'h00, rd);
    chk("in_ro", 32'(rd), 32'h00);
    acc(1'b0, 4'h7, 8'h00, rd);
    chk("set_reads0", 32'(rd), 32'h00);
    acc(1'b0, 4'h0, 8'h00, rd);
    chk("out_rd", 32'(rd), 32'h26);

    // sync latency: change sampled at edge C
    pad_in = 8'h3C;
    idle(1);
    acc(1'b0, 4'h3, 8'h00, rd);
    chk("in_c1", 32'(rd), 32'h00);
    acc(1'b0, 4'h3, 8'h00, rd);
    chk("in_c2", 32'(rd), 32'h3C);
    pad_in = 8'h00;
    idle(4);

    // rising edge on pin 0
    acc(1'b1, 4'h4, 8'h01, rd);
    pad_in = 8'h01;
    idle(2);
    chk("irq_c1", 32'(irq), 32'd0);
    acc(1'b0, 4'h6, 8'h00, rd);
    chk("status_c2", 32'(rd), 32'h00);
    chk("irq_c2", 32'(irq), 32'd0);
    acc(1'b0, 4'h6, 8'h00, rd);
    chk("status_c3", 32'(rd), 32'h01);
    chk("irq_c3", 32'(irq), 32'd1);
    acc(1'b1, 4'h6, 8'h01, rd);
    chk("irq_w1c_t", 32'(irq), 32'd1);
    idle(1);
    chk("irq_w1c_t1", 32'(irq), 32'd0);
    acc(1'b0, 4'h6, 8'h00, rd);
    chk("status_clr", 32'(rd), 32'h00);

    // fall on pin 2 colliding with a W1C of the same bit
    acc(1'b1, 4'h5, 8'h04, rd);
    pad_in = 8'h05;
    idle(4);
    acc(1'b0, 4'h6, 8'h00, rd);
    chk("status_pre_fall", 32'(rd), 32'h00);
    pad_in = 8'h01;
    idle(2);
    acc(1'b1, 4'h6, 8'h04, rd);
    acc(1'b0, 4'h6, 8'h00, rd);
    chk("set_wins", 32'(rd), 32'h04);
    chk("irq_set_wins", 32'(irq), 32'd1);
    acc(1'b1, 4'h5, 8'h00, rd);
    acc(1'b0, 4'h6, 8'h00, rd);
    chk("dis_keeps", 32'(rd), 32'h04);
    acc(1'b1, 4'h6, 8'h04, rd);
    idle(1);
    chk("irq_fall_clr", 32'(irq), 32'd0);

    // unmapped write ignored, unmapped read acked with 0
    acc(1'b1, 4'hC, 8'h55, rd);
    acc(1'b0, 4'hC, 8'h00, rd);
    chk("unmapped_rd", 32'(rd), 32'h00);
    map_exp = '{8'h26, 8'h0F, 8'hF0, 8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00};
    for (int a = 0; a < 9; a++) begin
      acc(1'b0, 4'(a), 8'h00, rd);
      chk($sformatf("map_rd_%0h", a), 32'(rd), 32'(map_exp[a]));
    end
    chk("pad_out_keep", 32'(pad_out), 32'h26);

    // reset asserted during a write: no commit, ack dropped
    bus.reg_req   = 1'b1;
    bus.reg_we    = 1'b1;
    bus.reg_addr  = 4'h0;
    bus.reg_wdata = 8'hFF;
    #2 rst = 1'b1;
    pad_in = 8'hFF;
    @(posedge clk);
    #1;
    chk("mid_rst_ack", 32'(bus.reg_ack), 32'd0);
    chk("mid_rst_out", 32'(pad_out), 32'h00);
    bus.reg_req   = 1'b0;
    bus.reg_we    = 1'b0;
    bus.reg_wdata = 8'h00;
    idle(2);
    rst = 1'b0;

    // blanking: pins high at reset release never flag a rise
    acc(1'b1, 4'h4, 8'hFF, rd);
    idle(6);
    acc(1'b0, 4'h6, 8'h00, rd);
    chk("blank_status", 32'(rd), 32'h00);
    chk("blank_irq", 32'(irq), 32'd0);
    acc(1'b0, 4'h3, 8'h00, rd);
    chk("blank_in", 32'(rd), 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
